io_arbiter: RTL and testbench

Sequences the CPU's single byte-wide I/O port across four peripheral channels. Posted CPU writes are buffered in a 4-entry FIFO and drained to the selected channel with a valid/ready handshake. CPU reads are ordered behind all pending writes, and the CPU is held via `io_stall` until read data returns. It sits between `cpu` (io_sel/io_data/io_output/io_reading) and the peripheral bank. A per-transfer watchdog prevents a dead channel from hanging the CPU.

---
 rtl/io_arbiter.sv | 161 ++++++++++++++++
 tb/tb_io_arbiter.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/io_arbiter.sv
// Arbitrates the CPU's byte-wide I/O port across four peripheral channels:
// posted writes are queued and drained in order, reads wait behind the queue.
module io_arbiter #(
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  io_sel,
  input  logic [7:0]  io_wdata,
  input  logic        io_output,
  input  logic        io_reading,
  output logic [7:0]  io_rdata,
  output logic        io_stall,
  output logic [3:0]  ch_valid,
  output logic        ch_we,
  output logic [7:0]  ch_wdata,
  input  logic [3:0]  ch_ready,
  input  logic [31:0] ch_rdata,
  output logic        err
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned WW = $clog2(TIMEOUT + 1);

  typedef struct packed {
    logic [1:0] sel;
    logic [7:0] data;
  } wr_entry_t;

  typedef enum logic [1:0] {
    R_IDLE,
    R_FLUSH,
    R_REQ,
    R_DONE
  } rstate_t;

  wr_entry_t         fifo [DEPTH];
  wr_entry_t         head_e;
  logic [PW-1:0]     head;
  logic [PW-1:0]     tail;
  logic [CW-1:0]     count;
  logic [WW-1:0]     wd;
  logic [WW-1:0]     wd_d;
  rstate_t           rstate;
  rstate_t           rstate_d;

  logic              full;
  logic              wr_act;
  logic              rd_act;
  logic              act_ready;
  logic              xfer_to;
  logic              push;
  logic              pop;

  assign head_e = fifo[head];
  assign full   = (count == CW'(DEPTH));

  // Active transfer selection: a read request owns the channel bus, otherwise the FIFO head drains.
  always_comb begin
    ch_valid  = 4'b0000;
    ch_we     = 1'b0;
    ch_wdata  = 8'h00;
    wr_act    = 1'b0;
    rd_act    = 1'b0;
    act_ready = 1'b0;
    if (rstate == R_REQ) begin
      rd_act    = 1'b1;
      ch_valid  = 4'b0001 << io_sel;
      act_ready = ch_ready[io_sel];
    end else if (count != CW'(0)) begin
      wr_act    = 1'b1;
      ch_valid  = 4'b0001 << head_e.sel;
      ch_we     = 1'b1;
      ch_wdata  = head_e.data;
      act_ready = ch_ready[head_e.sel];
    end
  end

  assign xfer_to = (wr_act | rd_act) & ~act_ready & (wd == WW'(TIMEOUT - 1));
  assign push    = io_output & ~full & (rstate == R_IDLE) & ~io_reading;
  assign pop     = wr_act & (act_ready | xfer_to);

  // Watchdog restarts on idle, completion or abandonment.
  always_comb begin
    wd_d = wd + WW'(1);
    if (!(wr_act | rd_act) || act_ready || xfer_to) begin
      wd_d = '0;
    end
  end

  always_comb begin
    rstate_d = rstate;
    case (rstate)
      R_IDLE: begin
        if (io_reading) begin
          rstate_d = (count != CW'(0)) ? R_FLUSH : R_REQ;
        end
      end
      R_FLUSH: begin
        if (count == CW'(0)) begin
          rstate_d = R_REQ;
        end
      end
      R_REQ: begin
        if (act_ready || xfer_to) begin
          rstate_d = R_DONE;
        end
      end
      R_DONE:  rstate_d = R_IDLE;
      default: rstate_d = R_IDLE;
    endcase
  end

  assign io_stall = (io_output & full)
                  | (io_reading & (rstate != R_DONE))
                  | (io_output & (rstate != R_IDLE));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rstate   <= R_IDLE;
      head     <= '0;
      tail     <= '0;
      count    <= '0;
      wd       <= '0;
      io_rdata <= 8'h00;
      err      <= 1'b0;
    end else begin
      rstate <= rstate_d;
      wd     <= wd_d;
      if (push) begin
        tail <= tail + PW'(1);
      end
      if (pop) begin
        head <= head + PW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      if (rd_act && act_ready) begin
        io_rdata <= ch_rdata[{io_sel, 3'b000} +: 8];
      end else if (rd_act && xfer_to) begin
        io_rdata <= 8'hFF;
      end
      if (xfer_to) begin
        err <= 1'b1;
      end
    end
  end

  // Payload storage carries no reset; validity is tracked by count.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo[tail] <= '{sel: io_sel, data: io_wdata};
    end
  end

endmodule

// File: tb/tb_io_arbiter.sv
// Directed bench for io_arbiter: write drain, full-FIFO stall, ordered read,
// read/write timeouts, timeout boundary and mid-transfer reset.
module tb_io_arbiter;

  logic        clk;
  logic        rst;
  logic [1:0]  io_sel;
  logic [7:0]  io_wdata;
  logic        io_output;
  logic        io_reading;
  logic [7:0]  io_rdata;
  logic        io_stall;
  logic [3:0]  ch_valid;
  logic        ch_we;
  logic [7:0]  ch_wdata;
  logic [3:0]  ch_ready;
  logic [31:0] ch_rdata;
  logic        err;

  int n_cmp;
  int n_bad;

  io_arbiter #(.DEPTH(4), .TIMEOUT(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .io_sel     (io_sel),
    .io_wdata   (io_wdata),
    .io_output  (io_output),
    .io_reading (io_reading),
    .io_rdata   (io_rdata),
    .io_stall   (io_stall),
    .ch_valid   (ch_valid),
    .ch_we      (ch_we),
    .ch_wdata   (ch_wdata),
    .ch_ready   (ch_ready),
    .ch_rdata   (ch_rdata),
    .err        (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge; inputs are driven here.
  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  initial begin
    n_cmp      = 0;
    n_bad      = 0;
    rst        = 1'b0;
    io_sel     = 2'd0;
    io_wdata   = 8'h00;
    io_output  = 1'b0;
    io_reading = 1'b0;
    ch_ready   = 4'h0;
    ch_rdata   = 32'h0;

    // Reset state
    cyc();
    cyc();
    #1;
    check("rst_rdata", 32'(io_rdata), 32'h0);
    check("rst_valid", 32'(ch_valid), 32'h0);
    check("rst_we", 32'(ch_we), 32'h0);
    check("rst_wdata", 32'(ch_wdata), 32'h0);
    check("rst_err", 32'(err), 32'h0);
    check("rst_stall", 32'(io_stall), 32'h0);
    rst = 1'b1;
    cyc();

    // Four writes to ch0..3, all ready high: one beat per cycle
    ch_ready = 4'hF;
    for (int i = 0; i < 4; i++) begin
      io_output = 1'b1;
      io_sel    = 2'(i);
      io_wdata  = 8'h11 * 8'(i + 1);
      #1;
      check("w4_stall", 32'(io_stall), 32'h0);
      cyc();
      #1;
      check("w4_valid", 32'(ch_valid), 32'(4'b0001 << i));
      check("w4_wdata", 32'(ch_wdata), 32'(8'h11 * 8'(i + 1)));
      check("w4_we", 32'(ch_we), 32'h1);
    end
    io_output = 1'b0;
    cyc();
    #1;
    check("w4_idle_valid", 32'(ch_valid), 32'h0);
    check("w4_idle_wdata", 32'(ch_wdata), 32'h0);

    // Full FIFO: fifth write stalls until ch0 ready pulses
    ch_ready = 4'h0;
    io_sel   = 2'd0;
    for (int i = 0; i < 4; i++) begin
      io_output = 1'b1;
      io_wdata  = 8'hA1 + 8'(i);
      #1;
      check("full_push_stall", 32'(io_stall), 32'h0);
      cyc();
    end
    io_wdata = 8'hA5;
    #1;
    check("full_stall0", 32'(io_stall), 32'h1);
    cyc();
    #1;
    check("full_stall1", 32'(io_stall), 32'h1);
    cyc();
    ch_ready = 4'b0001;
    #1;
    check("full_stall_pulse", 32'(io_stall), 32'h1);
    check("full_head_a1", 32'(ch_wdata), 32'hA1);
    cyc();
    ch_ready = 4'b0000;
    #1;
    check("full_accept_stall", 32'(io_stall), 32'h0);
    check("full_head_a2", 32'(ch_wdata), 32'hA2);
    cyc();
    io_output = 1'b0;
    ch_ready  = 4'hF;
    for (int i = 0; i < 4; i++) begin
      #1;
      check("full_drain_valid", 32'(ch_valid), 32'h1);
      check("full_drain_wdata", 32'(ch_wdata), 32'(8'hA2 + 8'(i)));
      cyc();
    end
    #1;
    check("full_drain_done", 32'(ch_valid), 32'h0);
    check("full_err", 32'(err), 32'h0);

    // Read ch2 ordered behind two queued ch1 writes
    ch_ready  = 4'h0;
    io_output = 1'b1;
    io_sel    = 2'd1;
    io_wdata  = 8'h61;
    cyc();
    io_wdata = 8'h62;
    cyc();
    io_output  = 1'b0;
    io_reading = 1'b1;
    io_sel     = 2'd2;
    ch_rdata   = 32'h005A_0000;
    #1;
    check("rd_stall_idle", 32'(io_stall), 32'h1);
    check("rd_q_valid", 32'(ch_valid), 32'h2);
    cyc();
    ch_ready = 4'b0110;
    #1;
    check("rd_flush1_valid", 32'(ch_valid), 32'h2);
    check("rd_flush1_wdata", 32'(ch_wdata), 32'h61);
    check("rd_flush1_stall", 32'(io_stall), 32'h1);
    cyc();
    #1;
    check("rd_flush2_wdata", 32'(ch_wdata), 32'h62);
    check("rd_flush2_stall", 32'(io_stall), 32'h1);
    cyc();
    #1;
    check("rd_flush_empty_valid", 32'(ch_valid), 32'h0);
    check("rd_flush_empty_stall", 32'(io_stall), 32'h1);
    cyc();
    #1;
    check("rd_req_valid", 32'(ch_valid), 32'h4);
    check("rd_req_we", 32'(ch_we), 32'h0);
    check("rd_req_wdata", 32'(ch_wdata), 32'h0);
    check("rd_req_stall", 32'(io_stall), 32'h1);
    cyc();
    #1;
    check("rd_done_stall", 32'(io_stall), 32'h0);
    check("rd_done_rdata", 32'(io_rdata), 32'h5A);
    check("rd_done_valid", 32'(ch_valid), 32'h0);
    io_reading = 1'b0;
    cyc();
    #1;
    check("rd_hold_rdata", 32'(io_rdata), 32'h5A);
    ch_ready = 4'h0;

    // Read ch3 with ready stuck low: abandoned after TIMEOUT cycles
    io_reading = 1'b1;
    io_sel     = 2'd3;
    #1;
    check("rto_idle_stall", 32'(io_stall), 32'h1);
    cyc();
    for (int k = 0; k < 8; k++) begin
      #1;
      check("rto_valid", 32'(ch_valid), 32'h8);
      check("rto_stall", 32'(io_stall), 32'h1);
      check("rto_err_low", 32'(err), 32'h0);
      cyc();
    end
    #1;
    check("rto_done_stall", 32'(io_stall), 32'h0);
    check("rto_rdata", 32'(io_rdata), 32'hFF);
    check("rto_err", 32'(err), 32'h1);
    io_reading = 1'b0;
    cyc();
    cyc();
    #1;
    check("rto_err_sticky", 32'(err), 32'h1);
    check("rto_idle_valid", 32'(ch_valid), 32'h0);

    // Reset with three ch0 writes queued and stalled
    io_output = 1'b1;
    io_sel    = 2'd0;
    for (int i = 0; i < 3; i++) begin
      io_wdata = 8'h71 + 8'(i);
      cyc();
    end
    io_output = 1'b0;
    #1;
    check("mid_valid_pre", 32'(ch_valid), 32'h1);
    rst = 1'b0;
    #1;
    check("mid_rst_valid", 32'(ch_valid), 32'h0);
    check("mid_rst_we", 32'(ch_we), 32'h0);
    check("mid_rst_wdata", 32'(ch_wdata), 32'h0);
    check("mid_rst_err", 32'(err), 32'h0);
    check("mid_rst_rdata", 32'(io_rdata), 32'h0);
    check("mid_rst_stall", 32'(io_stall), 32'h0);
    cyc();
    rst = 1'b1;
    cyc();
    ch_ready  = 4'hF;
    io_output = 1'b1;
    io_sel    = 2'd2;
    io_wdata  = 8'h77;
    #1;
    check("post_rst_stall", 32'(io_stall), 32'h0);
    cyc();
    io_output = 1'b0;
    #1;
    check("post_rst_valid", 32'(ch_valid), 32'h4);
    check("post_rst_wdata", 32'(ch_wdata), 32'h77);
    cyc();
    #1;
    check("post_rst_idle", 32'(ch_valid), 32'h0);

    // Ready arrives on the TIMEOUT-th cycle: success, no error
    ch_ready  = 4'h0;
    io_output = 1'b1;
    io_sel    = 2'd1;
    io_wdata  = 8'h99;
    cyc();
    io_output = 1'b0;
    for (int k = 0; k < 7; k++) begin
      #1;
      check("edge_valid", 32'(ch_valid), 32'h2);
      cyc();
    end
    ch_ready = 4'b0010;
    #1;
    check("edge_last_valid", 32'(ch_valid), 32'h2);
    cyc();
    ch_ready = 4'h0;
    #1;
    check("edge_done_valid", 32'(ch_valid), 32'h0);
    check("edge_err", 32'(err), 32'h0);

    // Write timeout discards the entry and sets err
    io_output = 1'b1;
    io_wdata  = 8'h98;
    cyc();
    io_output = 1'b0;
    for (int k = 0; k < 8; k++) begin
      #1;
      check("wto_valid", 32'(ch_valid), 32'h2);
      cyc();
    end
    #1;
    check("wto_discard", 32'(ch_valid), 32'h0);
    check("wto_err", 32'(err), 32'h1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
